// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and the InvMixColumns FSM encoding.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } invmix_state_e;

    // Multiply by x (i.e. by 02) with reduction
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // 09 = 08 ^ 01
    function automatic logic [7:0] gmul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    // 0B = 08 ^ 02 ^ 01
    function automatic logic [7:0] gmul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    // 0D = 08 ^ 04 ^ 01
    function automatic logic [7:0] gmul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    // 0E = 08 ^ 04 ^ 02
    function automatic logic [7:0] gmul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column; a0 is the top byte.
module inv_mix_single_column
    import aes_pkg::*;
(
    input  aes_col_t col,
    output aes_col_t mixed
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    // Circulant matrix rows {0E 0B 0D 09} rotated right by one per row
    assign mixed[31:24] = gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3);
    assign mixed[23:16] = gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3);
    assign mixed[15:8]  = gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3);
    assign mixed[7:0]   = gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3);

endmodule

// File: rtl/inv_mixcolumn_seq.sv
// Handshaked InvMixColumns: latches one state, processes COLS_PER_CYCLE
// columns per clock through shared column units, then holds the result
// until the downstream stage accepts it.
module inv_mixcolumn_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         invmix_valid_i,
    output logic         invmix_ready_o,
    input  logic [127:0] invmix_i,
    output logic         invmix_valid_o,
    input  logic         invmix_ready_i,
    output logic [127:0] invmix_o
);

    localparam int         GROUPS   = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_GRP = 2'(GROUPS - 1);

    invmix_state_e state_reg;
    logic [1:0]    cnt_reg;
    logic          valid_reg;
    logic          ready_reg;
    aes_col_t      in_cols_reg  [4];
    aes_col_t      res_cols_reg [4];

    logic [1:0]    col_idx [COLS_PER_CYCLE];
    aes_col_t      col_in  [COLS_PER_CYCLE];
    aes_col_t      col_out [COLS_PER_CYCLE];

    // Lane gi works on column cnt*COLS_PER_CYCLE + gi of the latched state
    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            assign col_idx[gi] = 2'(int'(cnt_reg) * COLS_PER_CYCLE + gi);
            assign col_in[gi]  = in_cols_reg[col_idx[gi]];

            inv_mix_single_column u_col (
                .col   (col_in[gi]),
                .mixed (col_out[gi])
            );
        end
    endgenerate

    assign invmix_o       = {res_cols_reg[0], res_cols_reg[1], res_cols_reg[2], res_cols_reg[3]};
    assign invmix_valid_o = valid_reg;
    assign invmix_ready_o = ready_reg;

    // Control FSM with registered handshake outputs and the column datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            for (int c = 0; c < 4; c++) begin
                in_cols_reg[c]  <= '0;
                res_cols_reg[c] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (invmix_valid_i) begin
                        for (int c = 0; c < 4; c++) begin
                            in_cols_reg[c] <= invmix_i[127 - 32*c -: 32];
                        end
                        cnt_reg   <= 2'd0;
                        ready_reg <= 1'b0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                        res_cols_reg[col_idx[g]] <= col_out[g];
                    end
                    if (cnt_reg == LAST_GRP) begin
                        cnt_reg   <= 2'd0;
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 2'd1;
                    end
                end
                DONE: begin
                    // Result stays frozen until the downstream handshake
                    if (invmix_ready_i) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mixcolumn_seq.sv
// Self-checking bench for inv_mixcolumn_seq against a matrix-level GF(2^8) model.
module tb_inv_mixcolumn_seq;

    localparam int COLS = 1;
    localparam int LAT  = 4 / COLS;

    logic         clk;
    logic         rst;
    logic         valid_in;
    logic         ready_out;
    logic [127:0] data_in;
    logic         valid_out;
    logic         ready_in;
    logic [127:0] data_out;

    int errors = 0;
    int checks = 0;

    inv_mixcolumn_seq #(.COLS_PER_CYCLE(COLS)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .invmix_valid_i (valid_in),
        .invmix_ready_o (ready_out),
        .invmix_i       (data_in),
        .invmix_valid_o (valid_out),
        .invmix_ready_i (ready_in),
        .invmix_o       (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Carry-less multiply then polynomial reduction by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product per column: out[r] = sum_k coef[(k-r) mod 4] * a[k]
    function automatic logic [127:0] circ(input logic [127:0] s, input logic [31:0] coefs);
        logic [127:0] o;
        logic [7:0]   acc;
        logic [7:0]   cf [4];
        for (int i = 0; i < 4; i++) cf[i] = coefs[31 - 8*i -: 8];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(cf[(k - r) & 3], s[127 - 32*c - 8*k -: 8]);
                o[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_model(input logic [127:0] s);
        return circ(s, 32'h0e0b0d09);
    endfunction

    function automatic logic [127:0] fwd_model(input logic [127:0] s);
        return circ(s, 32'h02030101);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Bounded wait for valid_out; lat counts edges after the current sample point
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (!valid_out && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(LAT));
    endtask

    // Full transaction: accept, compute, handshake; called at posedge+1
    task automatic run_vec(input string tag, input logic [127:0] din, output logic [127:0] res);
        int w;
        int lat;
        w = 0;
        while (!ready_out && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_rdy_idle"}, 128'(ready_out), 128'd1);
        valid_in = 1'b1;
        data_in  = din;
        @(posedge clk); #1;
        valid_in = 1'b0;
        data_in  = rand128();
        check({tag, "_rdy_busy"}, 128'(ready_out), 128'd0);
        wait_valid(tag, lat);
        res = data_out;
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        check({tag, "_post_hs"}, {126'd0, valid_out, ready_out}, 128'd1);
        $display("txn %s in=%h out=%h lat=%0d", tag, din, res, lat);
    endtask

    logic [127:0] res, a_vec, b_vec, held, st;
    logic [127:0] bb_vec [8];
    logic [127:0] bb_out [$];
    int           bb_acc [8];
    int           lat;

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(valid_out), 128'd0);
        check("rst_out", data_out, 128'd0);
        check("rst_ready", 128'(ready_out), 128'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_ready", 128'(ready_out), 128'd1);
        check("rel_valid", 128'(valid_out), 128'd0);

        // Known-answer vectors
        run_vec("fips", 128'h046681e5e0cb199a48f8d37a2806264c, res);
        check("fips_out", res, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        run_vec("colid", 128'h8e4da1bc01010101c6c6c6c6d5d5d7d6, res);
        check("colid_out", res, 128'hdb13534501010101c6c6c6c6d4d4d4d5);

        // Backpressure with a competing request held on the input
        a_vec = rand128();
        b_vec = rand128();
        valid_in = 1'b1;
        data_in  = a_vec;
        @(posedge clk); #1;
        data_in = b_vec;
        wait_valid("bp_a", lat);
        held = data_out;
        check("bp_a_out", held, inv_model(a_vec));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 128'(valid_out), 128'd1);
            check("bp_hold_out", data_out, held);
            check("bp_hold_ready", 128'(ready_out), 128'd0);
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        check("bp_hs_ready", 128'(ready_out), 128'd1);
        check("bp_hs_valid", 128'(valid_out), 128'd0);
        @(posedge clk); #1;
        valid_in = 1'b0;
        data_in  = rand128();
        check("bp_b_accept", 128'(ready_out), 128'd0);
        wait_valid("bp_b", lat);
        check("bp_b_out", data_out, inv_model(b_vec));
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        $display("txn backpressure a=%h b=%h out=%h", a_vec, b_vec, data_out);

        // Asynchronous reset two cycles into BUSY
        a_vec = rand128();
        valid_in = 1'b1;
        data_in  = a_vec;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_valid", 128'(valid_out), 128'd0);
        check("mid_rst_out", data_out, 128'd0);
        check("mid_rst_ready", 128'(ready_out), 128'd1);
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("mid_rst_nostale", {126'd0, valid_out, ready_out}, 128'd1);
        end
        $display("txn midreset in=%h discarded", a_vec);
        b_vec = rand128();
        run_vec("after_rst", b_vec, res);
        check("after_rst_out", res, inv_model(b_vec));

        // Back-to-back stream with both handshakes held high
        for (int k = 0; k < 8; k++) bb_vec[k] = rand128();
        begin
            int  k;
            int  cyc;
            logic pre_ready, pre_valid;
            logic [127:0] pre_out;
            k   = 0;
            cyc = 0;
            ready_in = 1'b1;
            valid_in = 1'b1;
            data_in  = bb_vec[0];
            while (bb_out.size() < 8 && cyc < 400) begin
                pre_ready = ready_out;
                pre_valid = valid_out;
                pre_out   = data_out;
                @(posedge clk); #1;
                cyc++;
                if (pre_ready && valid_in) begin
                    bb_acc[k] = cyc;
                    k++;
                    if (k < 8) data_in = bb_vec[k];
                    else valid_in = 1'b0;
                end
                if (pre_valid) bb_out.push_back(pre_out);
            end
            valid_in = 1'b0;
            ready_in = 1'b0;
            check("bb_count", 128'(bb_out.size()), 128'd8);
            for (int i = 0; i < 8 && i < bb_out.size(); i++) begin
                check("bb_out", bb_out[i], inv_model(bb_vec[i]));
                if (i > 0)
                    check("bb_spacing", 128'(bb_acc[i] - bb_acc[i-1]), 128'(LAT + 2));
                $display("txn stream%0d in=%h out=%h", i, bb_vec[i], bb_out[i]);
            end
        end
        @(posedge clk); #1;

        // Round trip through the forward transform
        for (int n = 0; n < 1000; n++) begin
            st = rand128();
            run_vec("roundtrip", fwd_model(st), res);
            check("roundtrip_out", res, st);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_mixcolumn_seq.md
Name: inv_mixcolumn_seq

Overview:
- Registered, handshaked AES InvMixColumns unit for the AES-256 decrypt/verify path.
- Exact inverse of the existing combinational mixcolumn block.
- Accepts one 128-bit state and computes COLS_PER_CYCLE columns per clock through a shared column datapath.
- Presents the result under a valid/ready handshake to the next round stage.

Parameters:
- COLS_PER_CYCLE, default 1: columns processed per clock. Legal values are 1, 2, 4. Compute latency is 4/COLS_PER_CYCLE cycles.

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- invmix_valid_i  input  1  input state valid
- invmix_ready_o  output  1  unit can accept a state
- invmix_i  input  128  input state
- invmix_valid_o  output  1  result valid
- invmix_ready_i  input  1  downstream accepts result
- invmix_o  output  128  InvMixColumns result

Behaviour:
- State layout, FIPS-197 column-major:
  - column c = bits [127-32c -: 32]
  - row r of column c = bits [127-32c-8r -: 8]
- Per column (a0..a3), all arithmetic in GF(2^8) with polynomial 0x11B, using xtime chains (no LUTs):
  - b0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
  - the other rows are the same coefficients rotated
- FSM states:
  - IDLE: invmix_ready_o=1. On invmix_valid_i=1, latch invmix_i into the input register, clear the column counter, go to BUSY.
  - BUSY: invmix_ready_o=0. Each cycle compute COLS_PER_CYCLE columns starting at counter×COLS_PER_CYCLE, write them into the result register, and advance the counter. After the last group, go to DONE. invmix_valid_i is ignored.
  - DONE: invmix_valid_o=1 and invmix_o holds steady. On invmix_ready_i=1 (handshake), go to IDLE. Otherwise hold indefinitely.
- Timing, with the acceptance edge as E0:
  - invmix_valid_o rises after edge E0 + 4/COLS_PER_CYCLE.
  - invmix_ready_o returns high the cycle after the output handshake.
  - No same-cycle output-handshake/input-accept overlap.
- Reset (asynchronous, any state, including mid-BUSY):
  - state=IDLE, counter=0
  - invmix_valid_o=0, invmix_ready_o=1 after reset release
  - invmix_o=0, input register=0
  - A partially computed block is discarded; no output is produced for it.
- invmix_o:
  - Driven only from the result register.
  - Unwritten columns retain their previous value; only meaningful when invmix_valid_o=1.
  - invmix_o must not change while invmix_valid_o=1 and invmix_ready_i=0.
- Handshake rules:
  - invmix_valid_i asserted during BUSY/DONE is not consumed; upstream must hold it until ready.
  - Input data is sampled only on the accept edge; later changes to invmix_i do not affect the result.
- The counter is a 2-bit wrap-free range 0..(4/COLS_PER_CYCLE-1). With COLS_PER_CYCLE=4, BUSY lasts exactly one cycle.

Decomposition:
- Shared package aes_pkg:
  - typedef aes_state_t (logic [127:0]), aes_col_t (logic [31:0])
  - constant AES_POLY=8'h1B
  - functions xtime, gmul09, gmul0b, gmul0d, gmul0e
  - enum invmix_state_e {IDLE, BUSY, DONE}
- Sub-module inv_mix_single_column: combinational 32-bit column in/out. It is instantiated COLS_PER_CYCLE times via generate.

Test Plan:
- FIPS-197 round vector: invmix_i=128'h046681e5e0cb199a48f8d37a2806264c with valid high one cycle -> invmix_o=128'hd4bf5d30e0b452aeb84111f11e2798e5, invmix_valid_o rising 4 cycles after accept (COLS_PER_CYCLE=1), and 1 cycle after accept with COLS_PER_CYCLE=4.
- Column identities: columns 8e4da1bc, 01010101, c6c6c6c6, d5d5d7d6 (input 128'h8e4da1bc01010101c6c6c6c6d5d5d7d6) -> 128'hdb13534501010101c6c6c6c6d4d4d4d5.
- Round-trip: random states through mixcolumn then inv_mixcolumn_seq, 1000 vectors -> output equals original state each time.
- Backpressure: hold invmix_ready_i=0 for 10 cycles in DONE -> invmix_valid_o stays 1, invmix_o stable, invmix_ready_o=0. Drive a new invmix_valid_i meanwhile -> not accepted until the cycle after the handshake.
- Reset mid-operation: assert rst_i asynchronously (between clock edges) two cycles into BUSY -> invmix_valid_o=0 and invmix_o=0 immediately. After release, invmix_ready_o=1 and no stale result appears. The next vector completes correctly.
- Back-to-back stream: 8 vectors with invmix_valid_i and invmix_ready_i held high -> all 8 results correct, in order, one accept per (4/COLS_PER_CYCLE + 2) cycles.
